exception_sequencer: RTL and testbench
======================================

Name: exception_sequencer

Overview:
- Consumer side of the interrupt controller: takes masked causes `mca`, `jisr` and one-hot level `il`, and performs interrupt entry and `eret` return.
- Owns the special-purpose registers SR, ESR, ECA, EPC and EDATA. SR feeds back to the interrupt controller's `sr` input.
- Issues a PC redirect plus pipeline flush to the fetch stage through a valid/ready handshake.

Parameters:
- DW, 32, data/PC width.
- CW, 23, cause vector width.
- SISR, 32'h0000_0000, ISR entry address.
- REPEAT_MASK, 23'h000000, bit i set means cause i is repeat-type (EPC = pc_cur). Clear means continue-type (EPC = pc_next).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mca  in  CW  masked cause vector
- jisr  in  1  interrupt request (OR of mca)
- il  in  32  one-hot lowest active cause (ff1 output)
- pc_cur  in  DW  PC of interrupted instruction
- pc_next  in  DW  PC of its successor
- edata_in  in  DW  faulting address/data
- eret  in  1  return-from-exception strobe
- spr_we  in  1  SPR write enable (movg2s)
- spr_wa  in  3  SPR write index
- spr_wd  in  DW  SPR write data
- spr_ra  in  3  SPR read index
- spr_rd  out  DW  SPR read data (combinational)
- sr  out  DW  status register
- redirect_valid  out  1  redirect request
- redirect_pc  out  DW  redirect target
- redirect_ready  in  1  fetch accepts redirect
- flush  out  1  kill in-flight instructions
- busy  out  1  sequencer not IDLE; core stalls

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset` is synchronous and active-high.
- On reset:
  - SR, ESR, ECA, EPC and EDATA are all 0.
  - State is IDLE.
  - redirect_valid=0, flush=0, busy=0, redirect_pc=0.
- SPR index map: 0 SR, 1 ESR, 2 ECA, 3 EPC, 4 EDATA. Indices 5-7 read 0 and ignore writes.
- spr_rd reflects the register's current value, with no bypass of a same-cycle write.
- FSM states: IDLE and REDIRECT.
- IDLE, jisr=1 with mca[0]=0 (entry), in one edge:
  - ECA <= mca.
  - ESR <= SR.
  - SR <= 0.
  - EDATA <= edata_in.
  - EPC <= pc_cur if (il[CW-1:0] & REPEAT_MASK) != 0, else pc_next.
  - Target <= SISR. Go to REDIRECT.
- Reset cause: mca[0]=1 in any state (including REDIRECT):
  - SR <= 0, target <= SISR.
  - ESR, EPC, ECA and EDATA are unchanged.
  - Go to REDIRECT; a redirect pending in REDIRECT is replaced.
- IDLE, eret=1, jisr=0:
  - SR <= ESR, target <= EPC. Go to REDIRECT.
- Priority in IDLE: reset cause > jisr > eret > spr_we.
  - The losing eret is dropped.
  - spr_we is ignored in any cycle where entry or eret fires.
- REDIRECT:
  - redirect_valid=1, flush=1, busy=1, redirect_pc=target held stable.
  - On redirect_valid & redirect_ready, go to IDLE the next cycle.
  - No zero-cycle bubble requirement.
- REDIRECT ignores non-reset jisr, eret and spr_we. A pending cause stays asserted by its source and is taken after return to IDLE.
- Latency:
  - jisr sampled at edge N gives redirect_valid=1 from cycle N+1.
  - With redirect_ready tied high, busy deasserts at N+2.
- In IDLE, spr_we writes spr_wd to the indexed register at the next edge. A write to SR takes effect on the controller's masking in the following cycle.
- il is trusted to be one-hot or zero. Only bits [CW-1:0] are used.

Test Plan:
- Reset, then read SPR 0-7 -> all 0. redirect_valid=0, busy=0.
- Write SR=32'h0000_0002 via spr_we. Apply mca=23'h000002, il=32'h2, pc_cur=32'h100, pc_next=32'h104, REPEAT_MASK=0 -> next cycle ECA=2, ESR=2, SR=0, EPC=32'h104, redirect_pc=SISR, flush=1.
- Same as above but REPEAT_MASK=23'h000002 -> EPC=32'h100. Hold redirect_ready=0 for 3 cycles -> redirect_valid and redirect_pc stay stable, busy=1 throughout.
- After an entry with ESR=2 and EPC=32'h104, pulse eret -> SR=2, redirect_pc=32'h104 for one handshake, then IDLE.
- jisr, eret and spr_we(SR, 32'hFFFF) asserted in the same IDLE cycle -> entry taken, SR=0, the write is dropped.
- mca[0]=1 while in REDIRECT with target EPC -> redirect_pc switches to SISR, SR=0, ESR/EPC/ECA unchanged.

Source files
------------

// File: rtl/exception_sequencer.sv
// exception_sequencer: interrupt entry and eret return sequencer.
// Owns SR/ESR/ECA/EPC/EDATA and drives the fetch redirect handshake.
module exception_sequencer #(
  parameter int unsigned    DW          = 32,
  parameter int unsigned    CW          = 23,
  parameter logic [DW-1:0]  SISR        = '0,
  parameter logic [CW-1:0]  REPEAT_MASK = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] mca,
  input  logic          jisr,
  input  logic [31:0]   il,
  input  logic [DW-1:0] pc_cur,
  input  logic [DW-1:0] pc_next,
  input  logic [DW-1:0] edata_in,
  input  logic          eret,
  input  logic          spr_we,
  input  logic [2:0]    spr_wa,
  input  logic [DW-1:0] spr_wd,
  input  logic [2:0]    spr_ra,
  output logic [DW-1:0] spr_rd,
  output logic [DW-1:0] sr,
  output logic          redirect_valid,
  output logic [DW-1:0] redirect_pc,
  input  logic          redirect_ready,
  output logic          flush,
  output logic          busy
);

  typedef enum logic {
    S_IDLE,
    S_REDIRECT
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [DW-1:0] r_sr;
  logic [DW-1:0] r_esr;
  logic [CW-1:0] r_eca;
  logic [DW-1:0] r_epc;
  logic [DW-1:0] r_edata;
  logic [DW-1:0] r_target;

  logic          w_take_rst;
  logic          w_take_entry;
  logic          w_take_eret;
  logic          w_spr_wr;
  logic          w_in_redirect;
  logic          w_repeat;
  logic [31:0]   w_repeat_mask;

  // Mask is widened to the full il width so bits above CW never match.
  assign w_repeat_mask = 32'(REPEAT_MASK);
  assign w_repeat      = |(il & w_repeat_mask);
  assign w_in_redirect = (r_state == S_REDIRECT);

  // Next-state and event decode; reset cause preempts everything.
  always_comb begin
    w_state_nxt  = r_state;
    w_take_rst   = 1'b0;
    w_take_entry = 1'b0;
    w_take_eret  = 1'b0;
    w_spr_wr     = 1'b0;
    if (mca[0]) begin
      w_take_rst  = 1'b1;
      w_state_nxt = S_REDIRECT;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (jisr) begin
            w_take_entry = 1'b1;
            w_state_nxt  = S_REDIRECT;
          end else if (eret) begin
            w_take_eret = 1'b1;
            w_state_nxt = S_REDIRECT;
          end else if (spr_we) begin
            w_spr_wr = 1'b1;
          end
        end
        S_REDIRECT: begin
          if (redirect_ready) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Handshake outputs are pure functions of the state.
  always_comb begin
    redirect_valid = w_in_redirect;
    flush          = w_in_redirect;
    busy           = w_in_redirect;
    redirect_pc    = w_in_redirect ? r_target : '0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Special-purpose registers and redirect target.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr     <= '0;
      r_esr    <= '0;
      r_eca    <= '0;
      r_epc    <= '0;
      r_edata  <= '0;
      r_target <= '0;
    end else if (w_take_rst) begin
      r_sr     <= '0;
      r_target <= SISR;
    end else if (w_take_entry) begin
      r_eca    <= mca;
      r_esr    <= r_sr;
      r_sr     <= '0;
      r_edata  <= edata_in;
      r_epc    <= w_repeat ? pc_cur : pc_next;
      r_target <= SISR;
    end else if (w_take_eret) begin
      r_sr     <= r_esr;
      r_target <= r_epc;
    end else if (w_spr_wr) begin
      unique case (spr_wa)
        3'd0:    r_sr    <= spr_wd;
        3'd1:    r_esr   <= spr_wd;
        3'd2:    r_eca   <= spr_wd[CW-1:0];
        3'd3:    r_epc   <= spr_wd;
        3'd4:    r_edata <= spr_wd;
        default: ;
      endcase
    end
  end

  // SPR read port, current register contents only.
  always_comb begin
    spr_rd = '0;
    unique case (spr_ra)
      3'd0:    spr_rd = r_sr;
      3'd1:    spr_rd = r_esr;
      3'd2:    spr_rd = DW'(r_eca);
      3'd3:    spr_rd = r_epc;
      3'd4:    spr_rd = r_edata;
      default: spr_rd = '0;
    endcase
  end

  assign sr = r_sr;

endmodule

// File: tb/tb_exception_sequencer.sv
// tb_exception_sequencer: directed plus randomized checks of
// exception_sequencer against a transaction-level model.
module tb_exception_sequencer;

  localparam int unsigned    DW   = 32;
  localparam int unsigned    CW   = 23;
  localparam logic [31:0]    SISR = 32'h0000_0080;
  localparam logic [CW-1:0]  RM   = 23'h00000A;
  localparam logic [31:0]    RM32 = 32'h0000_000A;

  logic          clk;
  logic          reset;
  logic [CW-1:0] mca;
  logic          jisr;
  logic [31:0]   il;
  logic [31:0]   pc_cur;
  logic [31:0]   pc_next;
  logic [31:0]   edata_in;
  logic          eret;
  logic          spr_we;
  logic [2:0]    spr_wa;
  logic [31:0]   spr_wd;
  logic [2:0]    spr_ra;
  logic [31:0]   spr_rd;
  logic [31:0]   sr;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          redirect_ready;
  logic          flush;
  logic          busy;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  exception_sequencer #(
    .DW(DW), .CW(CW), .SISR(SISR), .REPEAT_MASK(RM)
  ) dut (
    .clk(clk), .reset(reset), .mca(mca), .jisr(jisr), .il(il),
    .pc_cur(pc_cur), .pc_next(pc_next), .edata_in(edata_in),
    .eret(eret), .spr_we(spr_we), .spr_wa(spr_wa), .spr_wd(spr_wd),
    .spr_ra(spr_ra), .spr_rd(spr_rd), .sr(sr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .flush(flush), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: architectural registers plus "a redirect is outstanding".
  logic [31:0] m_sr, m_esr, m_eca, m_epc, m_edata, m_target;
  bit          m_pend;

  initial begin
    m_sr = 0; m_esr = 0; m_eca = 0; m_epc = 0;
    m_edata = 0; m_target = 0; m_pend = 0;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_sr <= 0; m_esr <= 0; m_eca <= 0; m_epc <= 0;
      m_edata <= 0; m_target <= 0; m_pend <= 0;
    end else if (mca[0]) begin
      m_sr <= 0;
      m_target <= SISR;
      m_pend <= 1;
    end else if (!m_pend) begin
      if (jisr) begin
        m_eca <= 32'(mca);
        m_esr <= m_sr;
        m_sr <= 0;
        m_edata <= edata_in;
        m_epc <= ((il & RM32) != 0) ? pc_cur : pc_next;
        m_target <= SISR;
        m_pend <= 1;
      end else if (eret) begin
        m_sr <= m_esr;
        m_target <= m_epc;
        m_pend <= 1;
      end else if (spr_we) begin
        case (spr_wa)
          3'd0: m_sr <= spr_wd;
          3'd1: m_esr <= spr_wd;
          3'd2: m_eca <= spr_wd & 32'h007F_FFFF;
          3'd3: m_epc <= spr_wd;
          3'd4: m_edata <= spr_wd;
          default: ;
        endcase
      end
    end else if (redirect_ready) begin
      m_pend <= 0;
    end
  end

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return m_sr;
      3'd1: return m_esr;
      3'd2: return m_eca;
      3'd3: return m_epc;
      3'd4: return m_edata;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", 32'(redirect_valid), 32'(m_pend));
      chk("m_flush", 32'(flush), 32'(m_pend));
      chk("m_busy", 32'(busy), 32'(m_pend));
      chk("m_rpc", redirect_pc, m_pend ? m_target : 32'h0);
      chk("m_sr", sr, m_sr);
      chk("m_spr_rd", spr_rd, m_read(spr_ra));
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic quiet;
    mca = 0; jisr = 0; il = 0; eret = 0; spr_we = 0;
  endtask

  initial begin
    quiet();
    reset = 1; redirect_ready = 1;
    pc_cur = 0; pc_next = 0; edata_in = 0;
    spr_wa = 0; spr_wd = 0; spr_ra = 0;
    tick(); tick();
    reset = 0; chk_en = 1;
    chk("rst_valid", 32'(redirect_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_rpc", redirect_pc, 0);
    for (int i = 0; i < 8; i++) begin
      spr_ra = 3'(i);
      tick();
      chk("rst_spr", spr_rd, 0);
    end

    // SR write, then repeat-type entry held for three cycles
    spr_we = 1; spr_wa = 0; spr_wd = 32'h2; spr_ra = 0;
    tick();
    spr_we = 0;
    chk("sr_write", sr, 32'h2);
    mca = 23'h2; jisr = 1; il = 32'h2;
    pc_cur = 32'h100; pc_next = 32'h104; edata_in = 32'hDEAD_BEEF;
    redirect_ready = 0; spr_ra = 2;
    tick();
    quiet();
    chk("ent_valid", 32'(redirect_valid), 1);
    chk("ent_flush", 32'(flush), 1);
    chk("ent_rpc", redirect_pc, SISR);
    chk("ent_sr", sr, 0);
    chk("ent_eca", spr_rd, 32'h2);
    spr_ra = 1; tick();
    chk("ent_esr", spr_rd, 32'h2);
    chk("hold_rpc1", redirect_pc, SISR);
    spr_ra = 3; tick();
    chk("ent_epc_rep", spr_rd, 32'h100);
    chk("hold_busy", 32'(busy), 1);
    spr_ra = 4; tick();
    chk("ent_edata", spr_rd, 32'hDEAD_BEEF);
    chk("hold_valid", 32'(redirect_valid), 1);
    redirect_ready = 1; tick();
    chk("hs_done", 32'(busy), 0);

    // continue-type entry, busy drops two edges later
    spr_we = 1; spr_wa = 0; spr_wd = 32'h2; tick();
    spr_we = 0;
    mca = 23'h4; jisr = 1; il = 32'h4; spr_ra = 3;
    tick();
    quiet();
    chk("cont_valid", 32'(redirect_valid), 1);
    chk("cont_epc", spr_rd, 32'h104);
    tick();
    chk("cont_busy_n2", 32'(busy), 0);

    // eret returns to EPC with SR restored
    eret = 1; spr_ra = 0; tick();
    eret = 0;
    chk("eret_sr", sr, 32'h2);
    chk("eret_rpc", redirect_pc, 32'h104);
    chk("eret_valid", 32'(redirect_valid), 1);
    tick();
    chk("eret_idle", 32'(redirect_valid), 0);

    // jisr + eret + SR write in one cycle: entry wins
    mca = 23'h8; jisr = 1; il = 32'h8; eret = 1;
    spr_we = 1; spr_wa = 0; spr_wd = 32'hFFFF;
    tick();
    quiet();
    chk("pri_sr", sr, 0);
    chk("pri_rpc", redirect_pc, SISR);
    spr_ra = 1; tick();
    chk("pri_esr", spr_rd, 32'h2);
    chk("pri_sr2", sr, 0);

    // reset cause replaces a pending eret redirect
    eret = 1; redirect_ready = 0; tick();
    eret = 0;
    chk("rc_eret_rpc", redirect_pc, 32'h100);
    chk("rc_eret_sr", sr, 32'h2);
    mca = 23'h1; jisr = 1; il = 32'h1; tick();
    quiet();
    chk("rc_rpc", redirect_pc, SISR);
    chk("rc_sr", sr, 0);
    chk("rc_valid", 32'(redirect_valid), 1);
    spr_ra = 1; tick();
    chk("rc_esr", spr_rd, 32'h2);
    spr_ra = 3; tick();
    chk("rc_epc", spr_rd, 32'h100);
    spr_ra = 2; tick();
    chk("rc_eca", spr_rd, 32'h8);
    redirect_ready = 1; tick();
    chk("rc_done", 32'(redirect_valid), 0);

    // randomized traffic, checked cycle-by-cycle by the model
    for (int n = 0; n < 3000; n++) begin
      logic [CW-1:0] c;
      reset = ($urandom_range(0, 99) == 0);
      c = '0;
      if ($urandom_range(0, 99) < 15) begin
        c = CW'($urandom & $urandom & $urandom) & ~CW'(1);
        if (c == 0) c = CW'(1) << $urandom_range(1, CW - 1);
      end
      if ($urandom_range(0, 49) == 0) c[0] = 1'b1;
      mca = c;
      jisr = |c;
      il = 0;
      for (int b = CW - 1; b >= 0; b--)
        if (c[b]) il = 32'(1) << b;
      eret = ($urandom_range(0, 9) == 0);
      spr_we = ($urandom_range(0, 4) == 0);
      spr_wa = 3'($urandom_range(0, 7));
      spr_wd = $urandom;
      spr_ra = 3'($urandom_range(0, 7));
      pc_cur = $urandom;
      pc_next = $urandom;
      edata_in = $urandom;
      redirect_ready = ($urandom_range(0, 9) < 7);
      tick();
    end

    quiet();
    reset = 0;
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
